// File: rtl/arb_mux.sv
// Registered N:1 arbitrating multiplexer: merges DEPTH valid/ready channels onto
// one single-entry output stage using fixed-priority or round-robin arbitration.
module arb_mux #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int ARB_MODE  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
  input  logic [DEPTH-1:0]           in_valid,
  output logic [DEPTH-1:0]           in_ready,
  input  logic                       sel_en,
  input  logic [SEL_WIDTH-1:0]       select,
  output logic [BIT_WIDTH-1:0]       muxout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEL_WIDTH-1:0]       out_sel
);

  logic [BIT_WIDTH-1:0] muxout_q, muxout_d;
  logic                 out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                 load;
  logic [DEPTH-1:0]     elig;
  logic [DEPTH-1:0]     grant;
  logic                 found;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic [SEL_WIDTH-1:0] start_idx;
  logic [BIT_WIDTH-1:0] gnt_data;
  int                   idx;

  // Wraps at DEPTH rather than 2**SEL_WIDTH so non-power-of-2 depths stay in range.
  function automatic logic [SEL_WIDTH-1:0] next_ptr(input logic [SEL_WIDTH-1:0] cur);
    if (int'(cur) == DEPTH - 1) begin
      return '0;
    end
    return cur + 1'b1;
  endfunction

  // Nothing is accepted while reset is held, so in_ready stays low in reset.
  assign load = rst_n && (!out_valid_q || out_ready);

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = in_valid[i] && (!sel_en || (int'(select) == i));
    end
  end

  always_comb begin
    start_idx = (ARB_MODE == 1) ? rr_ptr_q : '0;
    found     = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = int'(start_idx) + k;
      if (idx >= DEPTH) begin
        idx = idx - DEPTH;
      end
      if (!found && elig[idx]) begin
        found      = 1'b1;
        gnt_idx    = SEL_WIDTH'(idx);
        gnt_data   = dataIn[BIT_WIDTH*idx +: BIT_WIDTH];
        grant[idx] = load;
      end
    end
  end

  assign in_ready = grant;

  always_comb begin
    muxout_d    = muxout_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        muxout_d  = gnt_data;
        out_sel_d = gnt_idx;
        if (ARB_MODE == 1) begin
          rr_ptr_d = next_ptr(gnt_idx);
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      muxout_q    <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      muxout_q    <= muxout_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign muxout    = muxout_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: round-robin and fixed-priority 8-channel instances
// plus a 5-channel round-robin instance for non-power-of-2 wrap.
module tb_arb_mux;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic [63:0] d_a;
  logic [7:0]  v_a, rdy_a, mo_a;
  logic        sen_a, ov_a, or_a;
  logic [2:0]  sel_a, os_a;

  logic [63:0] d_b;
  logic [7:0]  v_b, rdy_b, mo_b;
  logic        sen_b, ov_b, or_b;
  logic [2:0]  sel_b, os_b;

  logic [39:0] d_c;
  logic [4:0]  v_c, rdy_c;
  logic [7:0]  mo_c;
  logic        sen_c, ov_c, or_c;
  logic [2:0]  sel_c, os_c;

  arb_mux #(.BIT_WIDTH(8), .DEPTH(8), .SEL_WIDTH(3), .ARB_MODE(1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .dataIn(d_a), .in_valid(v_a), .in_ready(rdy_a),
    .sel_en(sen_a), .select(sel_a), .muxout(mo_a), .out_valid(ov_a),
    .out_ready(or_a), .out_sel(os_a));

  arb_mux #(.BIT_WIDTH(8), .DEPTH(8), .SEL_WIDTH(3), .ARB_MODE(0)) u_fp8 (
    .clk(clk), .rst_n(rst_n), .dataIn(d_b), .in_valid(v_b), .in_ready(rdy_b),
    .sel_en(sen_b), .select(sel_b), .muxout(mo_b), .out_valid(ov_b),
    .out_ready(or_b), .out_sel(os_b));

  arb_mux #(.BIT_WIDTH(8), .DEPTH(5), .SEL_WIDTH(3), .ARB_MODE(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .dataIn(d_c), .in_valid(v_c), .in_ready(rdy_c),
    .sel_en(sen_c), .select(sel_c), .muxout(mo_c), .out_valid(ov_c),
    .out_ready(or_c), .out_sel(os_c));

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL rst_init_valid got=%h want=0", ov_a); end
    total++; if (mo_a !== 8'h00) begin bad++; $display("FAIL rst_init_data got=%h want=00", mo_a); end
    @(negedge clk);
    rst_n = 1'b1;
    v_a = 8'hFF;
    or_a = 1'b1;
    cyc();
    total++; if (ov_a !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%h want=1", ov_a); end
    total++; if (mo_a !== 8'h10) begin bad++; $display("FAIL rst_pre_data got=%h want=10", mo_a); end
    cyc();
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%h want=0", ov_a); end
    total++; if (mo_a !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h want=00", mo_a); end
    total++; if (os_a !== 3'd0) begin bad++; $display("FAIL rst_mid_sel got=%h want=0", os_a); end
    total++; if (rdy_a !== 8'h00) begin bad++; $display("FAIL rst_mid_ready got=%h want=00", rdy_a); end
    v_a = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rr_back_to_back();
    int ch;
    v_a = 8'hFF;
    or_a = 1'b1;
    sen_a = 1'b0;
    #1;
    total++; if (rdy_a !== 8'h01) begin bad++; $display("FAIL rr_first_ready got=%h want=01", rdy_a); end
    for (int k = 0; k <= 8; k++) begin
      ch = k % 8;
      cyc();
      total++; if (os_a !== 3'(ch)) begin bad++; $display("FAIL rr_sel[%0d] got=%0d want=%0d", k, os_a, ch); end
      total++; if (mo_a !== 8'(8'h10 + ch)) begin bad++; $display("FAIL rr_data[%0d] got=%h want=%h", k, mo_a, 8'(8'h10 + ch)); end
      total++; if (ov_a !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%h want=1", k, ov_a); end
      total++; if (rdy_a !== 8'(1 << ((ch + 1) % 8))) begin bad++; $display("FAIL rr_ready[%0d] got=%h want=%h", k, rdy_a, 8'(1 << ((ch + 1) % 8))); end
    end
    v_a = 8'h00;
    cyc();
    total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL rr_drain_valid got=%h want=0", ov_a); end
  endtask

  task automatic test_fixed_priority();
    v_b = 8'b1010_0100;
    or_b = 1'b1;
    sen_b = 1'b0;
    #1;
    total++; if (rdy_b !== 8'h04) begin bad++; $display("FAIL fp_first_ready got=%h want=04", rdy_b); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (mo_b !== 8'h12) begin bad++; $display("FAIL fp_data[%0d] got=%h want=12", k, mo_b); end
      total++; if (os_b !== 3'd2) begin bad++; $display("FAIL fp_sel[%0d] got=%0d want=2", k, os_b); end
      total++; if (ov_b !== 1'b1) begin bad++; $display("FAIL fp_valid[%0d] got=%h want=1", k, ov_b); end
      total++; if (rdy_b !== 8'h04) begin bad++; $display("FAIL fp_ready[%0d] got=%h want=04", k, rdy_b); end
    end
    v_b = 8'h00;
  endtask

  task automatic test_backpressure();
    v_a = 8'h20;
    or_a = 1'b1;
    cyc();
    total++; if (mo_a !== 8'h15) begin bad++; $display("FAIL bp_load_data got=%h want=15", mo_a); end
    total++; if (os_a !== 3'd5) begin bad++; $display("FAIL bp_load_sel got=%0d want=5", os_a); end
    or_a = 1'b0;
    v_a = 8'hFF;
    #1;
    total++; if (rdy_a !== 8'h00) begin bad++; $display("FAIL bp_stall_ready got=%h want=00", rdy_a); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (mo_a !== 8'h15) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h want=15", k, mo_a); end
      total++; if (ov_a !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%h want=1", k, ov_a); end
      total++; if (rdy_a !== 8'h00) begin bad++; $display("FAIL bp_hold_ready[%0d] got=%h want=00", k, rdy_a); end
    end
    or_a = 1'b1;
    #1;
    total++; if (rdy_a !== 8'h40) begin bad++; $display("FAIL bp_release_ready got=%h want=40", rdy_a); end
    cyc();
    total++; if (mo_a !== 8'h16) begin bad++; $display("FAIL bp_next_data got=%h want=16", mo_a); end
    total++; if (os_a !== 3'd6) begin bad++; $display("FAIL bp_next_sel got=%0d want=6", os_a); end
    total++; if (ov_a !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%h want=1", ov_a); end
    v_a = 8'h00;
    cyc();
  endtask

  task automatic test_forced_select();
    sen_a = 1'b1;
    sel_a = 3'd3;
    v_a = 8'hFF;
    or_a = 1'b1;
    #1;
    total++; if (rdy_a !== 8'h08) begin bad++; $display("FAIL fs_first_ready got=%h want=08", rdy_a); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (mo_a !== 8'h13) begin bad++; $display("FAIL fs_data[%0d] got=%h want=13", k, mo_a); end
      total++; if (os_a !== 3'd3) begin bad++; $display("FAIL fs_sel[%0d] got=%0d want=3", k, os_a); end
      total++; if (rdy_a !== 8'h08) begin bad++; $display("FAIL fs_ready[%0d] got=%h want=08", k, rdy_a); end
    end
    or_a = 1'b0;
    v_a = 8'hF7;
    cyc();
    total++; if (ov_a !== 1'b1) begin bad++; $display("FAIL fs_pending_valid got=%h want=1", ov_a); end
    or_a = 1'b1;
    #1;
    total++; if (rdy_a !== 8'h00) begin bad++; $display("FAIL fs_noelig_ready got=%h want=00", rdy_a); end
    cyc();
    total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL fs_drain_valid got=%h want=0", ov_a); end
    total++; if (mo_a !== 8'h13) begin bad++; $display("FAIL fs_drain_data got=%h want=13", mo_a); end
    total++; if (os_a !== 3'd3) begin bad++; $display("FAIL fs_drain_sel got=%0d want=3", os_a); end
    sen_a = 1'b0;
    v_a = 8'h00;
  endtask

  task automatic test_non_pow2();
    or_c = 1'b1;
    sen_c = 1'b0;
    v_c = 5'b01000;
    cyc();
    total++; if (os_c !== 3'd3) begin bad++; $display("FAIL np_setup_sel got=%0d want=3", os_c); end
    v_c = 5'b00011;
    #1;
    total++; if (rdy_c !== 5'b00001) begin bad++; $display("FAIL np_wrap_ready got=%b want=00001", rdy_c); end
    cyc();
    total++; if (os_c !== 3'd0) begin bad++; $display("FAIL np_wrap_sel got=%0d want=0", os_c); end
    total++; if (mo_c !== 8'h20) begin bad++; $display("FAIL np_wrap_data got=%h want=20", mo_c); end
    total++; if (rdy_c !== 5'b00010) begin bad++; $display("FAIL np_next_ready got=%b want=00010", rdy_c); end
    cyc();
    total++; if (os_c !== 3'd1) begin bad++; $display("FAIL np_next_sel got=%0d want=1", os_c); end
    total++; if (mo_c !== 8'h21) begin bad++; $display("FAIL np_next_data got=%h want=21", mo_c); end
    sen_c = 1'b1;
    sel_c = 3'd6;
    v_c = 5'b11111;
    #1;
    total++; if (rdy_c !== 5'b00000) begin bad++; $display("FAIL np_oob_ready got=%b want=00000", rdy_c); end
    cyc();
    total++; if (ov_c !== 1'b0) begin bad++; $display("FAIL np_oob_valid got=%h want=0", ov_c); end
    total++; if (mo_c !== 8'h21) begin bad++; $display("FAIL np_oob_data got=%h want=21", mo_c); end
    total++; if (os_c !== 3'd1) begin bad++; $display("FAIL np_oob_sel got=%0d want=1", os_c); end
    v_c = 5'b00000;
    sen_c = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d_a[8*i +: 8] = 8'(8'h10 + i);
      d_b[8*i +: 8] = 8'(8'h10 + i);
    end
    for (int i = 0; i < 5; i++) begin
      d_c[8*i +: 8] = 8'(8'h20 + i);
    end
    v_a = '0; sen_a = 1'b0; sel_a = '0; or_a = 1'b0;
    v_b = '0; sen_b = 1'b0; sel_b = '0; or_b = 1'b0;
    v_c = '0; sen_c = 1'b0; sel_c = '0; or_c = 1'b0;
    test_reset();
    test_rr_back_to_back();
    test_fixed_priority();
    test_backpressure();
    test_forced_select();
    test_non_pow2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
